nonce_scheduler: RTL and testbench

NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

---
 rtl/nonce_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_nonce_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_scheduler.sv
// nonce_scheduler: hands out nonces of one job to NUM_ENG hash engines and
// writes each engine's H0 result to base + nonce.
// Optional build macro: NONCE_SCHEDULER_RR_EN selects a round-robin result
// arbiter; without it the lowest pending engine index always wins.
//
// Engine handshake: eng_start[i] is a one-cycle launch pulse carrying
// eng_nonce; the engine answers later with a one-cycle eng_done[i] pulse and
// eng_hash slice i valid in that same cycle. There is no back-pressure: a
// completion is accepted only while engine i is busy and has no unwritten
// result, otherwise it is dropped.
module nonce_scheduler #(
  parameter int NUM_ENG    = 4,
  parameter int NUM_NONCES = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [15:0]            hash_out_addr,
  output logic                   done,
  output logic [NUM_ENG-1:0]     eng_start,
  output logic [31:0]            eng_nonce,
  input  logic [NUM_ENG-1:0]     eng_done,
  input  logic [32*NUM_ENG-1:0]  eng_hash,
  output logic                   mem_we,
  output logic [15:0]            memory_addr,
  output logic [31:0]            memory_write_data,
  output logic [1:0]             dbg_state
);

  localparam int         EW   = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam logic [8:0] LAST = 9'(NUM_NONCES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_DRAIN    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         base_q, base_d;
  logic [8:0]          next_nonce_q, next_nonce_d;
  logic [8:0]          written_q, written_d;
  logic [NUM_ENG-1:0]  busy_q, busy_d;
  logic [NUM_ENG-1:0]  pending_q, pending_d;
  logic [31:0]         hash_q [NUM_ENG];
  logic [31:0]         hash_d [NUM_ENG];
  logic [7:0]          nonce_q [NUM_ENG];
  logic [7:0]          nonce_d [NUM_ENG];
  logic [NUM_ENG-1:0]  eng_start_q, eng_start_d;
  logic [31:0]         eng_nonce_q, eng_nonce_d;
  logic                mem_we_q, mem_we_d;
  logic [15:0]         mem_addr_q, mem_addr_d;
  logic [31:0]         mem_data_q, mem_data_d;

  logic                launch_valid;
  logic [EW-1:0]       launch_idx;
  logic                do_launch;
  logic                grant_valid;
  logic [EW-1:0]       grant_idx;

  // Lowest-index idle engine is the launch candidate.
  always_comb begin
    launch_valid = 1'b0;
    launch_idx   = '0;
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        launch_valid = 1'b1;
        launch_idx   = EW'(i);
      end
    end
    do_launch = (state_q == S_DISPATCH) && (next_nonce_q < LAST) && launch_valid;
  end

`ifdef NONCE_SCHEDULER_RR_EN
  logic [EW-1:0] rr_last_q, rr_last_d;

  // Round-robin grant: search starts at the engine after the last one granted.
  always_comb begin
    int c;
    c           = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_ENG; k >= 1; k--) begin
      c = (int'(rr_last_q) + k) % NUM_ENG;
      if (pending_q[c]) begin
        grant_valid = 1'b1;
        grant_idx   = EW'(c);
      end
    end
    rr_last_d = grant_valid ? grant_idx : rr_last_q;
  end

  // Remembers the most recently granted engine.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_last_q <= '0;
    else          rr_last_q <= rr_last_d;
  end
`else
  // Fixed-priority grant: lowest pending engine index wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        grant_valid = 1'b1;
        grant_idx   = EW'(i);
      end
    end
  end
`endif

  // Next-state: FSM, launch, result capture and result write-back.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    next_nonce_d = next_nonce_q;
    written_d    = written_q;
    busy_d       = busy_q;
    pending_d    = pending_q;
    hash_d       = hash_q;
    nonce_d      = nonce_q;
    eng_start_d  = '0;
    eng_nonce_d  = '0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d       = hash_out_addr;
          next_nonce_d = '0;
          written_d    = '0;
          state_d      = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (next_nonce_q == LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((written_q == LAST) && (pending_q == '0)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Launch sets busy on an idle engine, so it never collides with a grant.
    if (do_launch) begin
      eng_start_d[launch_idx] = 1'b1;
      eng_nonce_d             = {24'd0, next_nonce_q[7:0]};
      busy_d[launch_idx]      = 1'b1;
      nonce_d[launch_idx]     = next_nonce_q[7:0];
      next_nonce_d            = next_nonce_q + 9'd1;
    end

    // Completions count only from a busy engine whose result is not yet held.
    for (int i = 0; i < NUM_ENG; i++) begin
      if (eng_done[i] && busy_q[i] && !pending_q[i]) begin
        pending_d[i] = 1'b1;
        hash_d[i]    = eng_hash[32*i +: 32];
      end
    end

    // Granted result goes out on the next edge and frees its engine.
    if (grant_valid) begin
      mem_we_d             = 1'b1;
      mem_addr_d           = base_q + {8'd0, nonce_q[grant_idx]};
      mem_data_d           = hash_q[grant_idx];
      pending_d[grant_idx] = 1'b0;
      busy_d[grant_idx]    = 1'b0;
      written_d            = written_q + 9'd1;
    end
  end

  // State and registered outputs; reset discards any in-flight work.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      next_nonce_q <= '0;
      written_q    <= '0;
      busy_q       <= '0;
      pending_q    <= '0;
      eng_start_q  <= '0;
      eng_nonce_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      for (int i = 0; i < NUM_ENG; i++) begin
        hash_q[i]  <= '0;
        nonce_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      next_nonce_q <= next_nonce_d;
      written_q    <= written_d;
      busy_q       <= busy_d;
      pending_q    <= pending_d;
      eng_start_q  <= eng_start_d;
      eng_nonce_q  <= eng_nonce_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      for (int i = 0; i < NUM_ENG; i++) begin
        hash_q[i]  <= hash_d[i];
        nonce_q[i] <= nonce_d[i];
      end
    end
  end

  assign done              = (state_q == S_IDLE);
  assign eng_start         = eng_start_q;
  assign eng_nonce         = eng_nonce_q;
  assign mem_we            = mem_we_q;
  assign memory_addr       = mem_addr_q;
  assign memory_write_data = mem_data_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler: behavioural engines answer with
// 0xA5000000 + nonce, and every launch and write is checked as it appears.
module tb_nonce_scheduler;

  localparam int NE = 4;
  localparam int NN = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic               start;
  logic [15:0]        hash_out_addr;
  logic               done;
  logic [NE-1:0]      eng_start;
  logic [31:0]        eng_nonce;
  logic [NE-1:0]      eng_done;
  logic [32*NE-1:0]   eng_hash;
  logic               mem_we;
  logic [15:0]        memory_addr;
  logic [31:0]        memory_write_data;
  logic [1:0]         dbg_state;

  nonce_scheduler #(.NUM_ENG(NE), .NUM_NONCES(NN)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .hash_out_addr     (hash_out_addr),
    .done              (done),
    .eng_start         (eng_start),
    .eng_nonce         (eng_nonce),
    .eng_done          (eng_done),
    .eng_hash          (eng_hash),
    .mem_we            (mem_we),
    .memory_addr       (memory_addr),
    .memory_write_data (memory_write_data),
    .dbg_state         (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int            n_vec = 0;
  int            n_bad = 0;
  logic [31:0]   exp_q[$];
  bit            auto_en;
  bit [NE-1:0]   job;
  bit [NE-1:0]   busy_m;
  int            cnt [NE];
  logic [31:0]   jnonce [NE];
  int            nonce_eng [NN];
  bit            wr_seen [NN];
  logic [15:0]   addr_of [NN];
  int            launch_cnt;
  int            wr_cnt;
  int            rr_last;
  logic [15:0]   job_base;
  logic [15:0]   last_addr;
  logic [31:0]   last_data;
  logic [NE-1:0] man_done;
  logic [32*NE-1:0] man_hash;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    job       = '0;
    busy_m    = '0;
    man_done  = '0;
    man_hash  = '0;
    last_addr = '0;
    last_data = '0;
    rr_last   = 0;
    exp_q.delete();
  endtask

  // ---------------- driver: one cycle, monitor then drive engines ----------------
  task automatic step();
    int n;
    int e;
    logic [15:0] exp_addr;
    @(negedge clk);
    if (reset_n) begin
      check_eq("start_onehot", 32'($onehot0(eng_start)), 32'd1);
      if (eng_start == '0) check_eq("nonce_idle", eng_nonce, 32'd0);
      for (int i = 0; i < NE; i++) begin
        if (eng_start[i]) begin
          check_eq("launch_busy", 32'(busy_m[i]), 32'd0);
          check_eq("launch_nonce", eng_nonce, 32'(launch_cnt));
          if (launch_cnt < NN) nonce_eng[launch_cnt] = i;
          busy_m[i] = 1'b1;
          job[i]    = 1'b1;
          jnonce[i] = eng_nonce;
          cnt[i]    = 3;
          launch_cnt++;
        end
      end
      if (mem_we) begin
        n = int'(memory_write_data - 32'hA500_0000);
        check_eq("wr_tag", {8'h00, memory_write_data[31:8]}, 32'h00A5_0000);
        if (n >= 0 && n < NN) begin
          exp_addr = job_base + 16'(n);
          check_eq("wr_addr", {16'h0, memory_addr}, {16'h0, exp_addr});
          check_eq("wr_dup", 32'(wr_seen[n]), 32'd0);
          wr_seen[n] = 1'b1;
          addr_of[n] = memory_addr;
          e = nonce_eng[n];
          busy_m[e] = 1'b0;
          rr_last   = e;
        end else begin
          check_eq("wr_range", memory_write_data, 32'hA500_0000);
        end
        wr_cnt++;
        last_addr = memory_addr;
        last_data = memory_write_data;
        if (exp_q.size() > 0) check_eq("wr_order", memory_write_data, exp_q.pop_front());
      end else begin
        check_eq("hold_addr", {16'h0, memory_addr}, {16'h0, last_addr});
        check_eq("hold_data", memory_write_data, last_data);
      end
    end
    eng_done = man_done;
    eng_hash = man_hash;
    man_done = '0;
    man_hash = '0;
    if (auto_en) begin
      for (int i = 0; i < NE; i++) begin
        if (job[i] && !eng_start[i]) begin
          if (cnt[i] > 1) cnt[i]--;
          else begin
            eng_done[i]          = 1'b1;
            eng_hash[32*i +: 32] = 32'hA500_0000 + jnonce[i];
            job[i]               = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic burst(input logic [NE-1:0] mask);
    for (int i = 0; i < NE; i++) begin
      if (mask[i]) begin
        man_hash[32*i +: 32] = 32'hA500_0000 + jnonce[i];
        job[i] = 1'b0;
      end
    end
    man_done = mask;
    step();
  endtask

  task automatic begin_job(input logic [15:0] base);
    launch_cnt = 0;
    wr_cnt     = 0;
    for (int i = 0; i < NN; i++) wr_seen[i] = 1'b0;
    job_base      = base;
    hash_out_addr = base;
    start         = 1'b1;
    step();
    start         = 1'b0;
    hash_out_addr = 16'h5A5A;
    check_eq("job_busy", 32'(done), 32'd0);
  endtask

  task automatic wait_launches(input int target, input int budget);
    int k;
    k = 0;
    while (launch_cnt < target && k < budget) begin step(); k++; end
    check_eq("launch_reach", 32'(launch_cnt), 32'(target));
  endtask

  task automatic wait_writes(input int target, input int budget);
    int k;
    k = 0;
    while (wr_cnt < target && k < budget) begin step(); k++; end
    check_eq("write_reach", 32'(wr_cnt), 32'(target));
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin step(); k++; end
    check_eq("job_done", 32'(done), 32'd1);
    check_eq("wr_total", 32'(wr_cnt), 32'(NN));
    check_eq("launch_total", 32'(launch_cnt), 32'(NN));
    check_eq("idle_state", {30'd0, dbg_state}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_we"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_start"}, {28'd0, eng_start}, 32'd0);
    check_eq({tag, "_nonce"}, eng_nonce, 32'd0);
    check_eq({tag, "_addr"}, {16'h0, memory_addr}, 32'd0);
    check_eq({tag, "_data"}, memory_write_data, 32'd0);
    check_eq({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n       = 1'b1;
    start         = 1'b0;
    hash_out_addr = '0;
    eng_done      = '0;
    eng_hash      = '0;
    auto_en       = 1'b0;
    launch_cnt    = 0;
    wr_cnt        = 0;
    job_base      = '0;
    model_clear();
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Job A: basic 16-nonce run.
    auto_en = 1'b1;
    begin_job(16'h0100);
    wait_done(400);
    check_eq("a_addr0", {16'h0, addr_of[0]}, 32'h0000_0100);
    check_eq("a_addr15", {16'h0, addr_of[15]}, 32'h0000_010F);

    // Spurious completion while idle: nothing may be written.
    man_done = 4'b0100;
    man_hash[95:64] = 32'hDEAD_BEEF;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("spur_idle_we", 32'(mem_we), 32'd0);
      check_eq("spur_idle_done", 32'(done), 32'd1);
    end

    // Job B: address wrap, plus spurious done[2] before engine 2 is launched.
    begin_job(16'hFFF8);
    man_done = 4'b0100;
    man_hash[95:64] = 32'hDEAD_BEEF;
    wait_done(400);
    check_eq("b_addr0", {16'h0, addr_of[0]}, 32'h0000_FFF8);
    check_eq("b_addr8", {16'h0, addr_of[8]}, 32'h0000_0000);
    check_eq("b_addr15", {16'h0, addr_of[15]}, 32'h0000_0007);

    // Job C: all engines finish together, then reset in DRAIN.
    auto_en = 1'b0;
    begin_job(16'h0200);
    wait_launches(4, 20);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("all_busy_hold", 32'(launch_cnt), 32'd4);
    end
`ifdef NONCE_SCHEDULER_RR_EN
    for (int k = 1; k <= NE; k++) exp_q.push_back(32'hA500_0000 + jnonce[(rr_last + k) % NE]);
`else
    for (int k = 0; k < NE; k++) exp_q.push_back(32'hA500_0000 + jnonce[k]);
`endif
    burst(4'hF);
    step();
    check_eq("burst_capture_we", 32'(mem_we), 32'd0);
    for (int k = 0; k < NE; k++) begin
      step();
      check_eq("burst_we", 32'(mem_we), 32'd1);
    end
    check_eq("burst_left", 32'(exp_q.size()), 32'd0);
    wait_launches(8, 20);
    burst(job);
    wait_launches(12, 20);
    burst(job);
    wait_launches(16, 20);
    wait_writes(12, 20);
    step();
    step();
    check_eq("drain_state", {30'd0, dbg_state}, 32'd2);
    burst(4'b0111);
    step();
    reset_n = 1'b0;
    #1 check_reset_outputs("mid");
    model_clear();
    step();
    check_reset_outputs("mid_next");
    reset_n = 1'b1;

    // Job D: fresh run after the mid-job reset.
    auto_en = 1'b1;
    begin_job(16'h0100);
    wait_done(400);
    check_eq("d_addr3", {16'h0, addr_of[3]}, 32'h0000_0103);
    check_eq("d_addr15", {16'h0, addr_of[15]}, 32'h0000_010F);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
